// File: rtl/md_seq_ctrl.sv
// -----------------------------------------------------------------------------
// md_seq_ctrl
//
// Sequencer for the multi-cycle MULT/MULTU/DIV/DIVU datapath in the EX stage.
// The sequencer does the following:
//   - It drives the iterative divider (load + per-iteration step) and the
//     pipelined multiplier enable.
//   - It holds md_stall while an operation runs.
//   - It pulses hilo_wen once the result is ready.
// An exception or flush (exc_oc) aborts an in-flight operation. An aborted
// operation never writes HI/LO.
//
// Optional feature macro: MD_DIV0_SKIP_EN
//   Defined     : a divide whose divisor is zero skips the iterations. It goes
//                 from IDLE straight to DONE after a single load cycle.
//   Not defined : ex_div_zero is ignored, and divide-by-zero runs all
//                 DIV_ITERS iterations.
//
// Parameters
//   DIV_ITERS  divider iterations (radix-2, one per cycle), >= 2
//   MUL_LAT    multiplier pipeline depth in cycles, >= 1
//   CNT_W      iteration counter width, holds max(DIV_ITERS, MUL_LAT)-1
//
// Ports
//   clk          in   core clock, rising edge
//   reset        in   asynchronous, active-high reset
//   ex_valid     in   EX holds a valid instruction
//   ex_mul_req   in   EX instruction is MULT/MULTU
//   ex_div_req   in   EX instruction is DIV/DIVU
//   ex_div_zero  in   divisor operand == 0 (only with MD_DIV0_SKIP_EN)
//   exc_oc       in   exception/flush occurs this cycle
//   md_stall     out  freeze IF/ID and ID/EX, bubble EX/MEM
//   md_busy      out  sequencer not in IDLE
//   div_load     out  1-cycle pulse, divider latches its operands
//   div_step     out  divider performs one iteration
//   mul_en       out  advance the multiplier pipeline
//   hilo_wen     out  1-cycle pulse, commit the result to HI/LO
//   md_cnt       out  current iteration count (debug/visibility)
// -----------------------------------------------------------------------------
module md_seq_ctrl #(
  parameter int unsigned DIV_ITERS = 32,
  parameter int unsigned MUL_LAT   = 2,
  parameter int unsigned CNT_W     = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ex_valid,
  input  logic             ex_mul_req,
  input  logic             ex_div_req,
  input  logic             ex_div_zero,
  input  logic             exc_oc,
  output logic             md_stall,
  output logic             md_busy,
  output logic             div_load,
  output logic             div_step,
  output logic             mul_en,
  output logic             hilo_wen,
  output logic [CNT_W-1:0] md_cnt
);

  // ---------------------------------------------------------------------------
  // State encoding
  // ---------------------------------------------------------------------------
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DIV  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // Final counter value of each operation. The count is compared before it
  // is incremented, so the counter stops at these values and never wraps.
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV_ITERS - 1);
  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // ---------------------------------------------------------------------------
  // Registers and next-state wires
  // ---------------------------------------------------------------------------
  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;

  logic [1:0]       w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;

  logic             w_go;
  logic             w_start_div;
  logic             w_start_mul;
  logic             w_div0_skip;

  logic             w_stall;
  logic             w_div_load;
  logic             w_div_step;
  logic             w_mul_en;
  logic             w_hilo_wen;

  // ---------------------------------------------------------------------------
  // Start decode (only used in IDLE)
  // ---------------------------------------------------------------------------
  // The state register is already IDLE while reset is held. Without the
  // reset gate, a pending request would still raise div_load, mul_en and
  // md_stall combinationally during reset.
  assign w_go = ex_valid & (ex_mul_req | ex_div_req) & ~exc_oc & ~reset;

  // When both requests are high (an illegal encoding), DIV wins.
  assign w_start_div = w_go & ex_div_req;
  assign w_start_mul = w_go & ~ex_div_req;

`ifdef MD_DIV0_SKIP_EN
  // A zero divisor skips the iterations. HI/LO then takes the divider's
  // load-state value, which is architecturally undefined.
  assign w_div0_skip = ex_div_zero;
`else
  // The divisor-zero flag is deliberately ignored, so divide-by-zero runs
  // all iterations.
  assign w_div0_skip = 1'b0 & ex_div_zero;
`endif

  // ---------------------------------------------------------------------------
  // Next-state and output decode
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here is given a default first. Otherwise a
    // path that skips an assignment would infer a latch.
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_stall     = 1'b0;
    w_div_load  = 1'b0;
    w_div_step  = 1'b0;
    w_mul_en    = 1'b0;
    w_hilo_wen  = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_start_div) begin
          w_div_load  = 1'b1;
          w_stall     = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = w_div0_skip ? ST_DONE : ST_DIV;
        end else if (w_start_mul) begin
          w_mul_en    = 1'b1;
          w_stall     = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = ST_MUL;
        end
      end

      ST_DIV: begin
        // A flush aborts the op. Stall and step still hold for this cycle.
        w_div_step = 1'b1;
        w_stall    = 1'b1;
        if (exc_oc) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == DIV_LAST) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end

      ST_MUL: begin
        w_mul_en = 1'b1;
        w_stall  = 1'b1;
        if (exc_oc) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == MUL_LAST) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end

      ST_DONE: begin
        // EX advances on this edge. The request that started the op may still
        // be high, so DONE always returns to IDLE and never restarts directly.
        w_hilo_wen  = ~exc_oc;
        w_cnt_nxt   = '0;
        w_state_nxt = ST_IDLE;
      end

      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and counter registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments, so every register
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign md_stall = w_stall;
  assign md_busy  = (r_state != ST_IDLE);
  assign div_load = w_div_load;
  assign div_step = w_div_step;
  assign mul_en   = w_mul_en;
  assign hilo_wen = w_hilo_wen;
  assign md_cnt   = r_cnt;

endmodule

// File: tb/tb_md_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_md_seq_ctrl
//
// Directed bench for md_seq_ctrl with default parameters
// (DIV_ITERS=32, MUL_LAT=2, CNT_W=6).
//
// Cycle numbering: cycle 1 is the cycle in which the request is first
// presented in IDLE. Outputs are sampled 3 time units after the rising edge,
// well away from both clock edges.
// -----------------------------------------------------------------------------
module tb_md_seq_ctrl;

  localparam int CNT_W = 6;

  logic             clk;
  logic             reset;
  logic             ex_valid;
  logic             ex_mul_req;
  logic             ex_div_req;
  logic             ex_div_zero;
  logic             exc_oc;
  logic             md_stall;
  logic             md_busy;
  logic             div_load;
  logic             div_step;
  logic             mul_en;
  logic             hilo_wen;
  logic [CNT_W-1:0] md_cnt;

  int n_pass  = 0;
  int n_total = 0;

  // Per-operation measurements filled in by measure()
  int   m_stall, m_load, m_step, m_mulen, m_hilo;
  int   m_hilo_cyc, m_last_step;
  logic busy_log [0:63];
  int   cnt_log  [0:63];

  md_seq_ctrl #(
    .DIV_ITERS(32),
    .MUL_LAT  (2),
    .CNT_W    (CNT_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .ex_valid   (ex_valid),
    .ex_mul_req (ex_mul_req),
    .ex_div_req (ex_div_req),
    .ex_div_zero(ex_div_zero),
    .exc_oc     (exc_oc),
    .md_stall   (md_stall),
    .md_busy    (md_busy),
    .div_load   (div_load),
    .div_step   (div_step),
    .mul_en     (mul_en),
    .hilo_wen   (hilo_wen),
    .md_cnt     (md_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The stimulus must never present both requests at once.
  always @(negedge clk)
    assert (!(ex_valid && ex_mul_req && ex_div_req))
      else $error("FAIL illegal_req: both mul and div requested");

  task automatic check(input string tag, input int obs, input int exp);
    n_total++;
    assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Runs ncyc cycles. The sequence is:
  //   - ex_valid is high for cycles 1..valid_last.
  //   - The request lines are held for the whole window.
  //   - exc_oc pulses in cycle exc_cyc (0 = never).
  // The task counts every output pulse.
  task automatic measure(input int ncyc, input int valid_last, input int exc_cyc,
                         input logic mul, input logic div, input logic zero);
    m_stall = 0; m_load = 0; m_step = 0; m_mulen = 0; m_hilo = 0;
    m_hilo_cyc = 0; m_last_step = 0;
    for (int c = 1; c <= ncyc; c++) begin
      ex_valid    = (c <= valid_last);
      ex_mul_req  = mul;
      ex_div_req  = div;
      ex_div_zero = zero;
      exc_oc      = (c == exc_cyc);
      #1;
      if (md_stall) m_stall++;
      if (div_load) m_load++;
      if (div_step) begin m_step++; m_last_step = c; end
      if (mul_en)   m_mulen++;
      if (hilo_wen) begin m_hilo++; m_hilo_cyc = c; end
      busy_log[c] = md_busy;
      cnt_log[c]  = int'(md_cnt);
      tick();
    end
    ex_valid = 1'b0; ex_mul_req = 1'b0; ex_div_req = 1'b0;
    ex_div_zero = 1'b0; exc_oc = 1'b0;
  endtask

  initial begin
    reset = 1'b1; ex_valid = 1'b0; ex_mul_req = 1'b0; ex_div_req = 1'b0;
    ex_div_zero = 1'b0; exc_oc = 1'b0;

    // ---- Reset state ------------------------------------------------------
    #3;
    check("rst_stall", md_stall, 0);
    check("rst_busy",  md_busy,  0);
    check("rst_cnt",   md_cnt,   0);
    tick(); tick();
    reset = 1'b0;

    // ---- 1. DIV, 32 iterations -------------------------------------------
    measure(38, 34, 0, 1'b0, 1'b1, 1'b0);
    check("div_stall_cycles", m_stall, 33);
    check("div_load_pulses",  m_load, 1);
    check("div_step_cycles",  m_step, 32);
    check("div_hilo_pulses",  m_hilo, 1);
    check("div_hilo_cycle",   m_hilo_cyc, 34);
    check("div_cnt_c2",       cnt_log[2], 0);
    check("div_cnt_c33",      cnt_log[33], 31);
    check("div_busy_c35",     busy_log[35], 0);
    check("div_cnt_c35",      cnt_log[35], 0);

    // ---- 2. MULT, 2-deep pipeline ----------------------------------------
    measure(6, 4, 0, 1'b1, 1'b0, 1'b0);
    check("mul_stall_cycles", m_stall, 3);
    check("mul_en_cycles",    m_mulen, 3);
    check("mul_hilo_cycle",   m_hilo_cyc, 4);
    check("mul_hilo_pulses",  m_hilo, 1);
    check("mul_no_div_step",  m_step, 0);
    check("mul_cnt_c3",       cnt_log[3], 1);
    check("mul_busy_c5",      busy_log[5], 0);

    // ---- 3. DIV aborted by exc_oc in cycle 10 ----------------------------
    measure(14, 10, 10, 1'b0, 1'b1, 1'b0);
    check("abort_hilo_pulses", m_hilo, 0);
    check("abort_last_step",   m_last_step, 10);
    check("abort_step_cycles", m_step, 9);
    check("abort_stall",       m_stall, 10);
    check("abort_cnt_c10",     cnt_log[10], 8);
    check("abort_busy_c11",    busy_log[11], 0);
    check("abort_cnt_c11",     cnt_log[11], 0);

    // ---- 4. Request held through DONE and one extra cycle ----------------
    measure(7, 4, 0, 1'b1, 1'b0, 1'b0);
    check("hold_hilo_pulses", m_hilo, 1);
    check("hold_mul_en",      m_mulen, 3);
    check("hold_busy_c5",     busy_log[5], 0);
    // A new instruction starts as soon as ex_valid re-asserts.
    ex_valid = 1'b1; ex_div_req = 1'b1;
    #1;
    check("restart_div_load", div_load, 1);
    check("restart_stall",    md_stall, 1);
    tick();
    ex_valid = 1'b0; ex_div_req = 1'b0;
    #1;
    check("restart_busy", md_busy, 1);
    for (int i = 0; i < 36; i++) tick();
    check("restart_idle", md_busy, 0);

    // ---- exc_oc in DONE suppresses the write -----------------------------
    measure(6, 4, 4, 1'b1, 1'b0, 1'b0);
    check("exc_done_hilo", m_hilo, 0);
    check("exc_done_busy", busy_log[5], 0);

    // ---- exc_oc in IDLE prevents a start ---------------------------------
    measure(2, 1, 1, 1'b0, 1'b1, 1'b0);
    check("exc_idle_load",  m_load, 0);
    check("exc_idle_stall", m_stall, 0);
    check("exc_idle_busy",  busy_log[2], 0);

    // ---- 5. Divide by zero -----------------------------------------------
`ifdef MD_DIV0_SKIP_EN
    measure(5, 2, 0, 1'b0, 1'b1, 1'b1);
    check("div0_stall",     m_stall, 1);
    check("div0_load",      m_load, 1);
    check("div0_steps",     m_step, 0);
    check("div0_hilo_cyc",  m_hilo_cyc, 2);
    check("div0_hilo_cnt",  m_hilo, 1);
`else
    measure(38, 34, 0, 1'b0, 1'b1, 1'b1);
    check("div0_stall",     m_stall, 33);
    check("div0_load",      m_load, 1);
    check("div0_steps",     m_step, 32);
    check("div0_hilo_cyc",  m_hilo_cyc, 34);
    check("div0_hilo_cnt",  m_hilo, 1);
`endif

    // ---- 6. Async reset at DIV cycle 5 -----------------------------------
    measure(4, 4, 0, 1'b0, 1'b1, 1'b0);
    ex_valid = 1'b1; ex_div_req = 1'b1;      // cycle 5, still in DIV
    #1;
    check("pre_rst_step", div_step, 1);
    check("pre_rst_cnt",  md_cnt, 3);
    reset = 1'b1;                            // mid-cycle, asynchronous
    #1;
    check("rst_mid_step",  div_step, 0);
    check("rst_mid_stall", md_stall, 0);
    check("rst_mid_load",  div_load, 0);
    check("rst_mid_busy",  md_busy, 0);
    check("rst_mid_cnt",   md_cnt, 0);
    check("rst_mid_hilo",  hilo_wen, 0);
    tick();
    #1;
    check("rst_hold_step", div_step, 0);
    check("rst_hold_busy", md_busy, 0);
    ex_valid = 1'b0; ex_div_req = 1'b0;
    reset = 1'b0;
    tick();
    #1;
    check("post_rst_busy", md_busy, 0);
    check("post_rst_hilo", hilo_wen, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
